// File: rtl/blink_pkg.sv
// Shared constants, FSM state type and round-constant step for the Blink-128 tweakey schedule.
package blink_pkg;
  localparam int BLOCK_LEN   = 128;
  localparam int TWEAKEY_LEN = 2 * BLOCK_LEN;
  localparam int NUM_ROUNDS  = 32;
  localparam int RC_W        = 6;
  localparam logic [RC_W-1:0] RC_INIT = 6'h01;

  typedef enum logic {IDLE, RUN} state_t;

  // Shift left, feeding back the inverted XOR of the top two bits.
  function automatic logic [RC_W-1:0] rc_next(input logic [RC_W-1:0] rc);
    return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  endfunction
endpackage

// File: rtl/tweakey_rc_lfsr.sv
// 6-bit round-constant register: clear wins over load, load wins over step.
module tweakey_rc_lfsr
  import blink_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            clear,
  output logic [RC_W-1:0] rc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc <= '0;
    end else if (clear) begin
      rc <= '0;
    end else if (load) begin
      rc <= RC_INIT;
    end else if (step) begin
      rc <= rc_next(rc);
    end
  end

endmodule

// File: rtl/tweakey_round_sched.sv
// Expands one hashed tweakey {TK2, TK1} into NUM_ROUNDS round keys RK = TK1 ^ TK2 ^ RC.
module tweakey_round_sched
  import blink_pkg::*;
#(
  parameter int BLOCK_LEN  = blink_pkg::BLOCK_LEN,
  parameter int NUM_ROUNDS = blink_pkg::NUM_ROUNDS,
  parameter int TK1_ROT    = 32,
  parameter int TK2_ROT    = 1,
  parameter int IDX_W      = $clog2(NUM_ROUNDS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tk_valid,
  output logic                   tk_ready,
  input  logic [2*BLOCK_LEN-1:0] tweakey,
  output logic                   rk_valid,
  input  logic                   rk_ready,
  output logic [BLOCK_LEN-1:0]   rk,
  output logic [IDX_W-1:0]       rk_idx,
  output logic                   rk_last,
  output logic                   busy
);

  localparam int R1 = TK1_ROT % BLOCK_LEN;
  localparam int R2 = TK2_ROT % BLOCK_LEN;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ROUNDS - 1);

  state_t                 state_reg;
  logic [BLOCK_LEN-1:0]   tk1_reg;
  logic [BLOCK_LEN-1:0]   tk2_reg;
  logic [BLOCK_LEN-1:0]   tk1_rot;
  logic [BLOCK_LEN-1:0]   tk2_rot;
  logic [IDX_W-1:0]       idx_reg;
  logic [RC_W-1:0]        rc;
  logic                   run;
  logic                   last;
  logic                   accept;
  logic                   advance;
  logic                   finish;

  assign run     = (state_reg == RUN);
  assign last    = run && (idx_reg == IDX_LAST);
  assign accept  = tk_valid && tk_ready;
  assign advance = run && rk_ready && !last;
  assign finish  = last && rk_ready && !tk_valid;

  // Only rk_ready reaches an output combinationally, and only through tk_ready.
  assign tk_ready = !run || (last && rk_ready);
  assign rk_valid = run;
  assign busy     = run;
  assign rk_idx   = idx_reg;
  assign rk_last  = last;
  assign rk       = run ? (tk1_reg ^ tk2_reg ^ {{(BLOCK_LEN-RC_W){1'b0}}, rc}) : '0;

  // Left rotations are pure wiring: bit gi moves to (gi + R) mod BLOCK_LEN.
  generate
    for (genvar gi = 0; gi < BLOCK_LEN; gi++) begin : g_rot
      assign tk1_rot[(gi + R1) % BLOCK_LEN] = tk1_reg[gi];
      assign tk2_rot[(gi + R2) % BLOCK_LEN] = tk2_reg[gi];
    end
  endgenerate

  tweakey_rc_lfsr u_rc (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .step  (advance),
    .clear (finish),
    .rc    (rc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      tk1_reg   <= '0;
      tk2_reg   <= '0;
      idx_reg   <= '0;
    end else if (accept) begin
      state_reg <= RUN;
      tk1_reg   <= tweakey[BLOCK_LEN-1:0];
      tk2_reg   <= tweakey[2*BLOCK_LEN-1:BLOCK_LEN];
      idx_reg   <= '0;
    end else if (advance) begin
      tk1_reg   <= tk1_rot;
      tk2_reg   <= tk2_rot;
      idx_reg   <= idx_reg + IDX_W'(1);
    end else if (finish) begin
      // Zeroize key material once the block is done.
      state_reg <= IDLE;
      tk1_reg   <= '0;
      tk2_reg   <= '0;
      idx_reg   <= '0;
    end
  end

endmodule

// File: tb/tb_tweakey_round_sched.sv
// Randomized and directed checks of tweakey_round_sched against a round-indexed key model.
module tb_tweakey_round_sched;
  localparam int NR = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tk_valid = 1'b0;
  logic         rk_ready = 1'b0;
  logic [255:0] tweakey = '0;
  logic         tk_ready, rk_valid, rk_last, busy;
  logic [127:0] rk;
  logic [4:0]   rk_idx;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  logic [5:0]   rc_tab [NR];
  bit           m_run;
  int           m_r;
  logic [127:0] m_tk1, m_tk2;

  always #5 clk = ~clk;

  tweakey_round_sched dut (
    .clk      (clk),
    .rst      (rst),
    .tk_valid (tk_valid),
    .tk_ready (tk_ready),
    .tweakey  (tweakey),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk       (rk),
    .rk_idx   (rk_idx),
    .rk_last  (rk_last),
    .busy     (busy)
  );

  function automatic logic [127:0] rotl(input logic [127:0] x, input int n);
    logic [255:0] d;
    d = {x, x} << (n % 128);
    return d[255:128];
  endfunction

  // Key for round r computed directly from the originally loaded halves.
  function automatic logic [127:0] exp_rk(input logic [127:0] t1, input logic [127:0] t2, input int r);
    return rotl(t1, 32 * r) ^ rotl(t2, r) ^ {122'b0, rc_tab[r]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idx(input int target);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rk_valid && rk_idx == 5'(target)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL wait_idx actual=timeout required=idx%0d", target);
    end
  endtask

  task automatic drain(inout int hs, inout int bad_last, inout int seen_last);
    for (int i = 0; i < 200; i++) begin
      if (!rk_valid) break;
      hs++;
      if (rk_last) begin
        if (rk_idx == 5'd31) seen_last++;
        else bad_last++;
      end
      tick();
    end
  endtask

  function automatic logic [255:0] rand_tk();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference model: which key (original halves) and which round is on the output.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 1'b0;
      m_r   = 0;
      m_tk1 = '0;
      m_tk2 = '0;
    end else if (m_run && rk_ready) begin
      if (m_r < NR - 1) begin
        m_r++;
      end else if (tk_valid) begin
        m_tk1 = tweakey[127:0];
        m_tk2 = tweakey[255:128];
        m_r   = 0;
      end else begin
        m_run = 1'b0;
        m_r   = 0;
      end
    end else if (!m_run && tk_valid) begin
      m_tk1 = tweakey[127:0];
      m_tk2 = tweakey[255:128];
      m_r   = 0;
      m_run = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("mon_rk_valid", 128'(rk_valid), 128'(m_run));
      chk("mon_busy", 128'(busy), 128'(m_run));
      chk("mon_rk", rk, m_run ? exp_rk(m_tk1, m_tk2, m_r) : 128'h0);
      chk("mon_rk_idx", 128'(rk_idx), m_run ? 128'(m_r) : 128'h0);
      chk("mon_rk_last", 128'(rk_last), 128'(m_run && m_r == NR - 1));
      chk("mon_tk_ready", 128'(tk_ready), 128'(!m_run || (m_r == NR - 1 && rk_ready)));
    end
  end

  initial begin
    logic [5:0]   rc;
    logic [127:0] held_rk;
    logic [255:0] nt;
    int hs, bad_last, seen_last;

    rc = 6'h01;
    for (int r = 0; r < NR; r++) begin
      rc_tab[r] = rc;
      rc = {rc[4:0], ~(rc[5] ^ rc[4])};
    end

    // Reset state
    repeat (2) tick();
    chk("rst_rk_valid", 128'(rk_valid), 128'h0);
    chk("rst_rk", rk, 128'h0);
    chk("rst_rk_idx", 128'(rk_idx), 128'h0);
    chk("rst_rk_last", 128'(rk_last), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_tk_ready", 128'(tk_ready), 128'h1);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Block A: TK1 = 1, TK2 = 0
    rk_ready = 1'b1;
    tk_valid = 1'b1;
    tweakey  = {128'h0, 128'h1};
    tick();
    chk("a_idx0_rk", rk, 128'h0);
    chk("a_idx0_idx", 128'(rk_idx), 128'h0);
    #1 tk_valid = 1'b0;
    tick();
    chk("a_idx1_rk", rk, 128'h1_0000_0003);
    tick();
    chk("a_idx2_rk", rk, 128'h1_0000_0000_0000_0007);
    hs = 2; bad_last = 0; seen_last = 0;
    drain(hs, bad_last, seen_last);
    chk("a_handshakes", 128'(hs), 128'd32);
    chk("a_last_wrong_idx", 128'(bad_last), 128'h0);
    chk("a_last_seen", 128'(seen_last), 128'h1);
    chk("a_idle_tk_ready", 128'(tk_ready), 128'h1);
    chk("a_idle_busy", 128'(busy), 128'h0);
    chk("a_zero_tk1", dut.tk1_reg, 128'h0);
    chk("a_zero_tk2", dut.tk2_reg, 128'h0);
    chk("a_zero_rc", 128'(dut.u_rc.rc), 128'h0);

    // Block B: TK1 = 0, TK2 = 1, then backpressure at idx 4
    #1 tk_valid = 1'b1;
    tweakey = {128'h1, 128'h0};
    tick();
    chk("b_idx0_rk", rk, 128'h0);
    #1 tk_valid = 1'b0;
    tick();
    chk("b_idx1_rk", rk, 128'h1);
    tick();
    chk("b_idx2_rk", rk, 128'h3);
    tick();
    chk("b_idx3_rk", rk, 128'h7);
    tick();
    chk("b_idx4_idx", 128'(rk_idx), 128'd4);
    held_rk = rk;
    #1 rk_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_rk", rk, held_rk);
      chk("bp_idx", 128'(rk_idx), 128'd4);
      chk("bp_last", 128'(rk_last), 128'h0);
    end
    #1 rk_ready = 1'b1;
    tick();
    chk("bp_resume_idx", 128'(rk_idx), 128'd5);

    // Back-to-back tweakey on the final handshake
    wait_idx(31);
    #1 tk_valid = 1'b1;
    nt = rand_tk();
    tweakey = nt;
    #1 chk("b2b_tk_ready", 128'(tk_ready), 128'h1);
    tick();
    chk("b2b_rk_valid", 128'(rk_valid), 128'h1);
    chk("b2b_idx", 128'(rk_idx), 128'h0);
    chk("b2b_rk", rk, nt[127:0] ^ nt[255:128] ^ 128'h1);
    #1 tk_valid = 1'b0;

    // Asynchronous reset mid-run
    wait_idx(10);
    #1 rst = 1'b1;
    #1;
    chk("arst_rk_valid", 128'(rk_valid), 128'h0);
    chk("arst_rk", rk, 128'h0);
    chk("arst_rk_idx", 128'(rk_idx), 128'h0);
    chk("arst_busy", 128'(busy), 128'h0);
    chk("arst_tk_ready", 128'(tk_ready), 128'h1);
    chk("arst_rc", 128'(dut.u_rc.rc), 128'h0);
    tick();
    #1 rst = 1'b0;
    tk_valid = 1'b1;
    nt = rand_tk();
    tweakey = nt;
    tick();
    chk("restart_idx", 128'(rk_idx), 128'h0);
    chk("restart_rc", 128'(dut.u_rc.rc), 128'h1);
    chk("restart_rk", rk, nt[127:0] ^ nt[255:128] ^ 128'h1);
    #1 tk_valid = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      #1;
      tk_valid = ($urandom % 3) == 0;
      rk_ready = ($urandom % 4) != 0;
      tweakey  = rand_tk();
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
